// File: rtl/milano_pkg.sv
// Shared types for the milano pipeline control slice: controller states,
// forwarding selects and the small destination tracker carried per stage.
package milano_pkg;

  typedef enum logic {
    CTRL_RUN      = 1'b0,
    CTRL_MDU_WAIT = 1'b1
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       wr;
    logic       load;
  } trk_t;

  localparam trk_t TRK_BUBBLE = '{rd: 5'd0, wr: 1'b0, load: 1'b0};

  // Operand source for one ID read; loads in EX cannot forward (load-use stalls instead).
  function automatic fwd_sel_e fwd_pick(input logic used, input logic [4:0] rs,
                                        input trk_t ex, input trk_t mem);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (used && (rs != 5'd0)) begin
      if (ex.wr && !ex.load && (ex.rd == rs)) sel = FWD_EX;
      else if (mem.wr && (mem.rd == rs))      sel = FWD_MEM;
    end
    return sel;
  endfunction

endpackage

// File: rtl/milano_pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, EX/MEM forwarding
// selects and a wait FSM around the multi-cycle MDU with a timeout guard.
module milano_pipe_ctrl
  import milano_pkg::*;
#(
  parameter int MDU_TIMEOUT = 40
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic [1:0] id_rs_used_i,
  input  logic [4:0] id_rd_addr_i,
  input  logic       id_rd_wr_en_i,
  input  logic       id_is_load_i,
  input  logic       id_is_mdu_i,
  input  logic       ex_branch_taken_i,
  input  logic       mdu_done_i,
  output logic       fe_stall_o,
  output logic       if_id_flush_o,
  output logic       id_ex_bubble_o,
  output logic       mdu_start_o,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o,
  output logic       mdu_timeout_o,
  output logic       ctrl_state_o
);

  localparam int CNT_W = $clog2(MDU_TIMEOUT + 1);

  ctrl_state_e      state_q, state_d;
  trk_t             ex_q, ex_d, mem_q, mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             tmo_q, tmo_d;
  logic             load_use, issue, stall, flush, bubble;
  fwd_sel_e         fwd_a, fwd_b;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CTRL_RUN;
      ex_q    <= TRK_BUBBLE;
      mem_q   <= TRK_BUBBLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ex_d    = ex_q;
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    tmo_d   = tmo_q;
    stall   = 1'b0;
    flush   = 1'b0;
    bubble  = 1'b0;
    issue   = 1'b0;
    load_use = id_valid_i && ex_q.load && ex_q.wr &&
               ((id_rs_used_i[0] && (id_rs1_addr_i == ex_q.rd)) ||
                (id_rs_used_i[1] && (id_rs2_addr_i == ex_q.rd)));
    case (state_q)
      CTRL_RUN: begin
        mem_d = ex_q;
        if (ex_branch_taken_i) begin
          flush  = 1'b1;
          bubble = 1'b1;
        end else if (load_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end else begin
          issue = id_valid_i;
        end
        if (issue) begin
          ex_d.rd   = id_rd_addr_i;
          ex_d.wr   = id_rd_wr_en_i && (id_rd_addr_i != 5'd0);
          ex_d.load = id_is_load_i;
        end else begin
          ex_d = TRK_BUBBLE;
        end
        if (issue && id_is_mdu_i) begin
          state_d = CTRL_MDU_WAIT;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      CTRL_MDU_WAIT: begin
        // EX holds the MDU op; it drains to MEM only in the done cycle.
        stall = !mdu_done_i;
        cnt_d = cnt_q + CNT_W'(1);
        mem_d = mdu_done_i ? ex_q : TRK_BUBBLE;
        if (mdu_done_i) begin
          state_d = CTRL_RUN;
        end else if (cnt_q == CNT_W'(MDU_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = CTRL_RUN;
        end
      end
      default: state_d = CTRL_RUN;
    endcase
    fwd_a = id_valid_i ? fwd_pick(id_rs_used_i[0], id_rs1_addr_i, ex_q, mem_q) : FWD_RF;
    fwd_b = id_valid_i ? fwd_pick(id_rs_used_i[1], id_rs2_addr_i, ex_q, mem_q) : FWD_RF;
  end

  // Reset forces every output quiet in the same cycle, not just after the edge.
  assign fe_stall_o     = stall && !rst_i;
  assign if_id_flush_o  = flush && !rst_i;
  assign id_ex_bubble_o = bubble && !rst_i;
  assign mdu_start_o    = start_q && !rst_i;
  assign mdu_timeout_o  = tmo_q && !rst_i;
  assign fwd_a_sel_o    = rst_i ? FWD_RF : fwd_a;
  assign fwd_b_sel_o    = rst_i ? FWD_RF : fwd_b;
  assign ctrl_state_o   = rst_i ? CTRL_RUN : state_q;

endmodule

// File: tb/tb_milano_pipe_ctrl.sv
// Bench for milano_pipe_ctrl: directed hazard scenarios plus random traffic,
// every cycle checked against a behavioural model of the pipeline.
module tb_milano_pipe_ctrl;
  import milano_pkg::*;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] used;
  logic       wr_en, is_load, is_mdu, branch, done;
  logic       fe_stall, flush, bubble, mdu_start, mdu_tmo, state;
  logic [1:0] fwd_a, fwd_b;

  always #5 clk = ~clk;

  milano_pipe_ctrl #(.MDU_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs_used_i(used),
    .id_rd_addr_i(rd), .id_rd_wr_en_i(wr_en), .id_is_load_i(is_load),
    .id_is_mdu_i(is_mdu), .ex_branch_taken_i(branch), .mdu_done_i(done),
    .fe_stall_o(fe_stall), .if_id_flush_o(flush), .id_ex_bubble_o(bubble),
    .mdu_start_o(mdu_start), .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b),
    .mdu_timeout_o(mdu_tmo), .ctrl_state_o(state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: which instruction sits in EX / MEM, plus the MDU wait.
  bit m_run = 1'b1;
  int m_waited = 0;
  bit m_tmo = 1'b0, m_start = 1'b0;
  int ex_rd = 0, mem_rd = 0;
  bit ex_wr = 1'b0, ex_ld = 1'b0, mem_wr = 1'b0;

  logic o_stall, o_flush, o_bubble, o_start, o_tmo, o_state;
  logic [1:0] o_fwd_a, o_fwd_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    return id_valid && ex_ld && ex_wr &&
           ((used[0] && int'(rs1) == ex_rd) || (used[1] && int'(rs2) == ex_rd));
  endfunction

  function automatic int m_fwd(input bit u, input int rs);
    if (!id_valid || !u || rs == 0) return int'(FWD_RF);
    if (ex_wr && !ex_ld && ex_rd == rs) return int'(FWD_EX);
    if (mem_wr && mem_rd == rs) return int'(FWD_MEM);
    return int'(FWD_RF);
  endfunction

  task automatic model_check();
    bit e_stall, e_flush, e_bubble;
    int e_a, e_b;
    e_stall = 0; e_flush = 0; e_bubble = 0;
    e_a = int'(FWD_RF); e_b = int'(FWD_RF);
    if (!rst) begin
      if (!m_run) e_stall = !done;
      else if (branch) begin e_flush = 1; e_bubble = 1; end
      else if (m_hazard()) begin e_stall = 1; e_bubble = 1; end
      e_a = m_fwd(used[0], int'(rs1));
      e_b = m_fwd(used[1], int'(rs2));
    end
    check("stall", o_stall, e_stall);
    check("flush", o_flush, e_flush);
    check("bubble", o_bubble, e_bubble);
    check("fwd_a", o_fwd_a, e_a);
    check("fwd_b", o_fwd_b, e_b);
    check("mdu_start", o_start, !rst && m_start);
    check("mdu_timeout", o_tmo, !rst && m_tmo);
    check("state", o_state, (rst || m_run) ? int'(CTRL_RUN) : int'(CTRL_MDU_WAIT));
  endtask

  task automatic model_step();
    bit issue;
    if (rst) begin
      m_run = 1; m_waited = 0; m_tmo = 0; m_start = 0;
      ex_wr = 0; ex_ld = 0; ex_rd = 0; mem_wr = 0; mem_rd = 0;
    end else if (m_run) begin
      issue = id_valid && !branch && !m_hazard();
      mem_rd = ex_rd; mem_wr = ex_wr;
      if (issue) begin
        ex_rd = int'(rd); ex_wr = wr_en && rd != 0; ex_ld = is_load;
      end else begin
        ex_rd = 0; ex_wr = 0; ex_ld = 0;
      end
      m_start = issue && is_mdu;
      if (m_start) begin m_run = 0; m_waited = 0; end
    end else begin
      m_start = 0;
      m_waited++;
      if (done) begin
        mem_rd = ex_rd; mem_wr = ex_wr; m_run = 1;
      end else begin
        mem_wr = 0;
        if (m_waited == TMO) begin m_tmo = 1; m_run = 1; end
      end
    end
  endtask

  // Inputs are set by the caller just after a rising edge; outputs sampled at the falling edge.
  task automatic run_cycle();
    @(negedge clk);
    o_stall = fe_stall; o_flush = flush; o_bubble = bubble; o_start = mdu_start;
    o_tmo = mdu_tmo; o_state = state; o_fwd_a = fwd_a; o_fwd_b = fwd_b;
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    rst = 0; id_valid = 0; rs1 = 0; rs2 = 0; used = 0; rd = 0;
    wr_en = 0; is_load = 0; is_mdu = 0; branch = 0; done = 0;
  endtask

  task automatic set_instr(input int a, input int b, input int u, input int d,
                           input bit w, input bit ld, input bit md);
    id_valid = 1; rs1 = 5'(a); rs2 = 5'(b); used = 2'(u); rd = 5'(d);
    wr_en = w; is_load = ld; is_mdu = md;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    repeat (n) run_cycle();
  endtask

  initial begin
    set_idle();
    rst = 1;
    repeat (2) run_cycle();
    check("rst_stall", o_stall, 0);
    check("rst_fwd_a", o_fwd_a, int'(FWD_RF));
    check("rst_tmo", o_tmo, 0);
    idle_cycles(2);

    // lw x5 then add x6,x5,x7
    set_instr(0, 0, 0, 5, 1, 1, 0);
    run_cycle();
    set_instr(5, 7, 3, 6, 1, 0, 0);
    run_cycle();
    check("lu_stall", o_stall, 1);
    check("lu_bubble", o_bubble, 1);
    run_cycle();
    check("lu_clear", o_stall, 0);
    check("lu_fwd_mem", o_fwd_a, int'(FWD_MEM));
    idle_cycles(2);

    // add x3 then sub x4,x1,x3 held in ID for two cycles
    set_instr(0, 0, 0, 3, 1, 0, 0);
    run_cycle();
    set_instr(1, 3, 3, 4, 1, 0, 0);
    run_cycle();
    check("fwd_ex", o_fwd_b, int'(FWD_EX));
    run_cycle();
    check("fwd_mem", o_fwd_b, int'(FWD_MEM));
    idle_cycles(2);

    // mul with done on the 4th wait cycle
    set_instr(1, 2, 3, 8, 1, 0, 1);
    run_cycle();
    check("mul_issue_start", o_start, 0);
    set_idle();
    for (int i = 1; i <= 4; i++) begin
      done = (i == 4);
      run_cycle();
      check($sformatf("mul_start_c%0d", i), o_start, i == 1);
      check($sformatf("mul_stall_c%0d", i), o_stall, i != 4);
    end
    set_idle();
    run_cycle();
    check("mul_back_run", o_state, int'(CTRL_RUN));
    idle_cycles(2);

    // branch while a load-use hazard is present, with an MDU op in ID
    set_instr(0, 0, 0, 5, 1, 1, 0);
    run_cycle();
    set_instr(5, 7, 3, 6, 1, 0, 1);
    branch = 1;
    run_cycle();
    check("br_flush", o_flush, 1);
    check("br_stall", o_stall, 0);
    set_idle();
    run_cycle();
    check("br_no_mdu", o_state, int'(CTRL_RUN));
    idle_cycles(2);

    // div that never completes
    set_instr(0, 0, 0, 9, 1, 0, 1);
    run_cycle();
    set_idle();
    repeat (TMO) run_cycle();
    check("tmo_last_stall", o_stall, 1);
    run_cycle();
    check("tmo_set", o_tmo, 1);
    check("tmo_run", o_state, int'(CTRL_RUN));
    repeat (3) run_cycle();
    check("tmo_sticky", o_tmo, 1);
    rst = 1;
    run_cycle();
    set_idle();
    run_cycle();
    check("tmo_cleared", o_tmo, 0);

    // reset in the 2nd wait cycle
    set_instr(0, 0, 0, 10, 1, 0, 1);
    run_cycle();
    set_idle();
    run_cycle();
    rst = 1;
    run_cycle();
    check("rst_wait_stall", o_stall, 0);
    check("rst_wait_state", o_state, int'(CTRL_RUN));
    set_idle();
    done = 1;
    run_cycle();
    check("rst_wait_run", o_state, int'(CTRL_RUN));
    check("rst_wait_nostart", o_start, 0);
    idle_cycles(1);

    for (int c = 0; c < 2000; c++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      used = 2'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 7));
      wr_en = ($urandom_range(0, 3) != 0);
      is_load = ($urandom_range(0, 3) == 0);
      is_mdu = ($urandom_range(0, 11) == 0);
      branch = ($urandom_range(0, 7) == 0);
      done = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 99) == 0);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
